// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one D latch bank.
// Each write is SETUP (data settles), ENABLE (EN high EN_CYCLES), HOLD (ACK).
module latch_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int EN_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ*WIDTH-1:0]   WDATA,
    output logic [N_REQ-1:0]         GNT,
    output logic [N_REQ-1:0]         ACK,
    output logic                     EN,
    output logic [WIDTH-1:0]         D,
    output logic                     BUSY
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EN_CYCLES - 1);
    localparam logic [PW-1:0] PTR_INIT = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state_r, state_n;
    logic [CW-1:0]      cnt_r, cnt_n;
    logic [PW-1:0]      ptr_r, ptr_n;
    logic [N_REQ-1:0]   gnt_r, gnt_n;
    logic [N_REQ-1:0]   ack_r, ack_n;
    logic               en_r, en_n;
    logic [WIDTH-1:0]   d_r, d_n;
    logic               busy_r, busy_n;

    logic [PW-1:0]      pick_s;
    logic [PW-1:0]      rr_s;
    logic               found_s;
    logic [N_REQ-1:0]   gnt_sel_s;
    logic [WIDTH-1:0]   wdata_sel_s;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        pick_s  = ptr_r;
        found_s = 1'b0;
        rr_s    = ptr_r;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_s = PW'((int'(ptr_r) + k) % N_REQ);
            if (!found_s && REQ[rr_s]) begin
                pick_s  = rr_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Decode the winner into a one-hot grant and select its data slice.
    always_comb begin
        gnt_sel_s   = {N_REQ{1'b0}};
        wdata_sel_s = {WIDTH{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_s == PW'(k)) begin
                gnt_sel_s[k] = 1'b1;
                wdata_sel_s  = WDATA[k*WIDTH +: WIDTH];
            end else begin
                gnt_sel_s[k] = 1'b0;
            end
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        ptr_n   = ptr_r;
        gnt_n   = gnt_r;
        ack_n   = {N_REQ{1'b0}};
        en_n    = 1'b0;
        d_n     = d_r;
        busy_n  = busy_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_n = SETUP;
                    gnt_n   = gnt_sel_s;
                    d_n     = wdata_sel_s;
                    ptr_n   = pick_s;
                    busy_n  = 1'b1;
                end else begin
                    gnt_n  = {N_REQ{1'b0}};
                    busy_n = 1'b0;
                end
            end
            SETUP: begin
                state_n = ENABLE;
                en_n    = 1'b1;
                cnt_n   = {CW{1'b0}};
            end
            ENABLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_n = HOLD;
                    ack_n   = gnt_r;
                end else begin
                    cnt_n = cnt_r + CW'(1);
                    en_n  = 1'b1;
                end
            end
            HOLD: begin
                state_n = IDLE;
                gnt_n   = {N_REQ{1'b0}};
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = {N_REQ{1'b0}};
                busy_n  = 1'b0;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any write without an ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            ptr_r   <= PTR_INIT;
            gnt_r   <= {N_REQ{1'b0}};
            ack_r   <= {N_REQ{1'b0}};
            en_r    <= 1'b0;
            d_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            ptr_r   <= ptr_n;
            gnt_r   <= gnt_n;
            ack_r   <= ack_n;
            en_r    <= en_n;
            d_r     <= d_n;
            busy_r  <= busy_n;
        end
    end

    assign GNT  = gnt_r;
    assign ACK  = ack_r;
    assign EN   = en_r;
    assign D    = d_r;
    assign BUSY = busy_r;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter: a transaction-age model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_latch_write_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int EC = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [N-1:0]     REQ;
    logic [N*W-1:0]   WDATA;
    logic [N-1:0]     GNT;
    logic [N-1:0]     ACK;
    logic             EN;
    logic [W-1:0]     D;
    logic             BUSY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    latch_write_arbiter #(.WIDTH(W), .N_REQ(N), .EN_CYCLES(EC)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WDATA(WDATA),
        .GNT(GNT), .ACK(ACK), .EN(EN), .D(D), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Model: m_age counts cycles since the grant edge (0 = idle).
    int           m_age   = 0;
    int           m_owner = 0;
    int           m_ptr   = N - 1;
    logic [W-1:0] m_d     = '0;
    bit           m_valid = 1'b0;

    always @(posedge CLK) begin
        int pick;
        pick = -1;
        if (RST) begin
            m_age   <= 0;
            m_d     <= '0;
            m_ptr   <= N - 1;
            m_valid <= 1'b1;
        end else if (m_age == 0) begin
            if (REQ != '0) begin
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && REQ[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                m_owner <= pick;
                m_ptr   <= pick;
                m_d     <= WDATA[pick*W +: W];
                m_age   <= 1;
            end
        end else begin
            m_age <= (m_age >= EC + 2) ? 0 : m_age + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        logic [N-1:0] e_gnt, e_ack;
        if (m_valid) begin
            e_gnt = (m_age != 0) ? (N'(1) << m_owner) : '0;
            e_ack = (m_age == EC + 2) ? (N'(1) << m_owner) : '0;
            chk("model_busy", 32'(BUSY), 32'(m_age != 0));
            chk("model_gnt",  32'(GNT),  32'(e_gnt));
            chk("model_ack",  32'(ACK),  32'(e_ack));
            chk("model_en",   32'(EN),   32'(m_age >= 2 && m_age <= EC + 1));
            chk("model_d",    32'(D),    32'(m_d));
        end
    end

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (GNT != '0) begin
                idx = oh_idx(GNT);
                break;
            end
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (ACK != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ack_seen", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int ack_cyc [5];
    int g;
    bit ok;

    initial begin
        RST = 1'b1; REQ = '0; WDATA = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_gnt",  32'(GNT),  32'h0);
        chk("rst_ack",  32'(ACK),  32'h0);
        chk("rst_en",   32'(EN),   32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_d",    32'(D),    32'h0);

        // Single write from requester 0 with exact cycle timing.
        REQ = 4'b0001; WDATA = 32'h0000_00A5;
        @(negedge CLK);
        chk("t1_gnt", 32'(GNT), 32'h1);
        chk("t1_d",   32'(D),   32'hA5);
        chk("t1_en",  32'(EN),  32'h0);
        @(negedge CLK); chk("t2_en", 32'(EN), 32'h1);
        @(negedge CLK); chk("t3_en", 32'(EN), 32'h1);
        @(negedge CLK);
        chk("t4_en",  32'(EN),  32'h0);
        chk("t4_ack", 32'(ACK), 32'h1);
        REQ = 4'b0000;
        @(negedge CLK);
        chk("t5_gnt",  32'(GNT),  32'h0);
        chk("t5_busy", 32'(BUSY), 32'h0);
        chk("t5_d",    32'(D),    32'hA5);

        // All requesters held high: rotation order and ACK spacing.
        do_reset();
        REQ = 4'b1111; WDATA = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            chk("rr_order", 32'(g), 32'(exp_order[k]));
            wait_ack(ok);
            ack_cyc[k] = cyc;
            if (k == 4) REQ = 4'b0000;
        end
        for (int k = 1; k < 5; k++)
            chk("ack_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd5);

        // WDATA change after grant is ignored.
        REQ = 4'b0010; WDATA = 32'h0000_3C00;
        wait_gnt(g);
        chk("hold_gnt1", 32'(g), 32'd1);
        chk("hold_d_setup", 32'(D), 32'h3C);
        @(negedge CLK);
        WDATA = 32'h0000_FF00;
        @(negedge CLK);
        chk("hold_d_enable", 32'(D), 32'h3C);
        wait_ack(ok);
        chk("hold_d_ack", 32'(D), 32'h3C);
        REQ = 4'b0000;
        @(negedge CLK);
        chk("hold_d_idle", 32'(D), 32'h3C);

        // Reset in the first ENABLE cycle aborts without ACK.
        REQ = 4'b0100; WDATA = 32'h0077_0000;
        wait_gnt(g);
        @(negedge CLK);
        chk("abort_en_before", 32'(EN), 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_en",   32'(EN),   32'h0);
        chk("abort_gnt",  32'(GNT),  32'h0);
        chk("abort_ack",  32'(ACK),  32'h0);
        chk("abort_busy", 32'(BUSY), 32'h0);
        chk("abort_d",    32'(D),    32'h0);
        RST = 1'b0; REQ = 4'b1001; WDATA = 32'h9900_0066;
        wait_gnt(g);
        chk("post_rst_first", 32'(g), 32'd0);
        wait_ack(ok);
        REQ = 4'b0000;
        @(negedge CLK);

        // Request dropped during SETUP still completes.
        REQ = 4'b0100; WDATA = 32'h005A_0000;
        wait_gnt(g);
        chk("drop_gnt", 32'(g), 32'd2);
        REQ = 4'b0000;
        @(negedge CLK); chk("drop_en1", 32'(EN), 32'h1);
        @(negedge CLK); chk("drop_en2", 32'(EN), 32'h1);
        @(negedge CLK); chk("drop_ack", 32'(ACK), 32'h4);
        @(negedge CLK);

        // Pointer wrap-around from requester 3 back to 0, then to 3.
        REQ = 4'b1000; WDATA = 32'hC300_0011;
        wait_gnt(g);
        chk("wrap_g3", 32'(g), 32'd3);
        wait_ack(ok);
        REQ = 4'b0000;
        @(negedge CLK);
        REQ = 4'b1001;
        wait_gnt(g);
        chk("wrap_g0", 32'(g), 32'd0);
        wait_ack(ok);
        REQ = 4'b1000;
        wait_gnt(g);
        chk("wrap_g3b", 32'(g), 32'd3);
        wait_ack(ok);
        REQ = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("idle_gnt", 32'(GNT), 32'h0);
        chk("idle_d",   32'(D),   32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data width of the shared latch bank.
REQ-002 The module SHALL have parameter N_REQ, default 4, number of requesters (N_REQ >= 2).
REQ-003 The module SHALL have parameter EN_CYCLES, default 2, number of cycles EN is held high per write (EN_CYCLES >= 1).
REQ-004 The module SHALL have port CLK  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 The module SHALL have port REQ  input  N_REQ  write request, bit i for requester i.
REQ-007 The module SHALL have port WDATA  input  N_REQ*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 The module SHALL have port GNT  output  N_REQ  one-hot grant to the requester currently owning the latch bank.
REQ-009 The module SHALL have port ACK  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 The module SHALL have port EN  output  1  enable to the shared D latch bank.
REQ-011 The module SHALL have port D  output  WIDTH  data to the shared D latch bank.
REQ-012 The module SHALL have port BUSY  output  1  high whenever a write transaction is in progress.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SETUP, ENABLE, HOLD; all outputs SHALL be registered.
REQ-014 In IDLE with any REQ bit set, the module SHALL grant round-robin, searching from the index after the last granted index; it SHALL then move to SETUP.
REQ-015 On grant, the module SHALL capture the granted WDATA slice into D, set GNT one-hot and record the granted index as the round-robin pointer, all visible in the SETUP cycle.
REQ-016 SETUP SHALL last 1 cycle with EN=0 and D stable, then move to ENABLE.
REQ-017 ENABLE SHALL last exactly EN_CYCLES cycles with EN=1, counted by an internal counter, then move to HOLD.
REQ-018 HOLD SHALL last 1 cycle with EN=0, D unchanged and ACK[granted]=1, then move to IDLE with GNT=0 and ACK=0.
REQ-019 Transaction timing SHALL be: REQ sampled in IDLE cycle t -> ACK in cycle t+2+EN_CYCLES -> back in IDLE at t+3+EN_CYCLES; IDLE lasts at least 1 cycle between transactions.
REQ-020 D SHALL NOT change in SETUP, ENABLE or HOLD; in IDLE, D SHALL keep the last written value until the next grant.
REQ-021 WDATA changes after the grant cycle SHALL be ignored.
REQ-022 A REQ bit deasserted mid-transaction SHALL NOT abort it; the transaction completes and ACK still pulses.
REQ-023 Requesters SHALL hold REQ until ACK; a REQ still high in the IDLE cycle after ACK SHALL be treated as a new request.
REQ-024 EN SHALL be 1 only in ENABLE; GNT SHALL have at most one bit set; ACK SHALL have at most one bit set, only in HOLD.
REQ-025 BUSY SHALL be 1 in SETUP, ENABLE and HOLD, and 0 in IDLE.
REQ-026 With REQ=0 in IDLE, the module SHALL stay in IDLE with all outputs unchanged.

Reset
REQ-027 With RST=1 at a rising edge, the next state SHALL be IDLE with EN=0, GNT=0, ACK=0, BUSY=0, D=0, counter=0 and pointer=N_REQ-1, so requester 0 has first priority.
REQ-028 Reset in any state, including mid-transaction, SHALL abort the transaction without an ACK; RST SHALL take priority over REQ.

Verification (WIDTH=8, N_REQ=4, EN_CYCLES=2)
REQ-029 Reset, then REQ=0001 with WDATA slice0=0xA5 in IDLE cycle t -> GNT=0001 and D=0xA5 from t+1; EN=1 in t+2 and t+3 only; ACK=0001 in t+4; IDLE with GNT=0 at t+5.
REQ-030 After reset, REQ=1111 held high -> grants in order 0,1,2,3,0; ACK pulses 5 cycles apart.
REQ-031 After grant to requester 1 with 0x3C, WDATA slice1 changes to 0xFF during ENABLE -> D stays 0x3C through HOLD and afterwards in IDLE.
REQ-032 RST=1 during the first ENABLE cycle -> next cycle EN=0, GNT=0, ACK=0, BUSY=0, D=0 and no ACK is issued; after release with REQ=1001, requester 0 is granted first.
REQ-033 REQ=0100 granted, then REQ dropped to 0000 during SETUP -> EN still pulses 2 cycles and ACK=0100 still pulses in HOLD.
REQ-034 After requester 3 completes, REQ=1001 -> requester 0 is granted (pointer wrap-around); after it completes, requester 3 is granted.
